// File: rtl/cpu_types.sv
// Shared pipeline types: the inter-stage status record and register-address helpers.
package cpu_types;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic            valid;
    reg_addr_t       address;
    logic [DATA_W-1:0] data;
  } wb_data_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] instruction;
    wb_data_t    data;
  } stage_status_t;

  // Idle trace record; ready stays high because this stage never stalls.
  localparam stage_status_t STAGE_IDLE = '{
    valid:       1'b0,
    ready:       1'b1,
    pc:          32'd0,
    instruction: 32'd0,
    data:        '0
  };

  function automatic logic writes_reg(input stage_status_t s);
    return s.valid & s.data.valid & (s.data.address != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: x0 reads as zero, one synchronous write port,
// two asynchronous read ports with optional same-cycle write bypass.
module reg_file
  import cpu_types::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_COUNT    = 32,
  parameter bit WRITE_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  reg_addr_t       waddr,
  input  logic [XLEN-1:0] wdata,
  input  reg_addr_t       a1,
  input  reg_addr_t       a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  localparam int              AW        = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(REG_COUNT);

  // Entry 0 is never stored; address 0 is decoded to a constant zero on read.
  logic [XLEN-1:0] regs_reg [1:REG_COUNT-1];

  reg_addr_t       rd_addr [2];
  logic [XLEN-1:0] rd_data [2];
  logic            write_ok;

  function automatic logic in_range(input reg_addr_t a);
    return {1'b0, a} < REG_LIMIT;
  endfunction

  assign write_ok = we && (waddr != REG_ZERO) && in_range(waddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (write_ok) begin
      regs_reg[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rd_addr[0] = a1;
  assign rd_addr[1] = a2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      assign rd_data[gi] =
        ((rd_addr[gi] == REG_ZERO) || !in_range(rd_addr[gi])) ? '0 :
        (WRITE_BYPASS && write_ok && (rd_addr[gi] == waddr)) ? wdata :
        regs_reg[rd_addr[gi][AW-1:0]];
    end
  endgenerate

  assign rd1 = rd_data[0];
  assign rd2 = rd_data[1];

endmodule

// File: rtl/register_writeback.sv
// Writeback stage: commits memory-stage results to the register file and
// keeps cycle/retire counters plus a one-cycle retire trace.
module register_writeback
  import cpu_types::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_COUNT    = 32,
  parameter bit WRITE_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  stage_status_t   stage_in,
  output stage_status_t   stage_out,
  input  logic [4:0]      reg_a1,
  input  logic [4:0]      reg_a2,
  output logic [XLEN-1:0] reg_rd1,
  output logic [XLEN-1:0] reg_rd2,
  output logic [63:0]     cycle_count,
  output logic [63:0]     retired_count,
  output logic            retire_valid,
  output logic [31:0]     retire_pc
);

  logic            we;
  logic [XLEN-1:0] wdata;

  logic [63:0]     cycle_count_reg;
  logic [63:0]     cycle_count_next;
  logic [63:0]     retired_count_reg;
  logic [63:0]     retired_count_next;
  stage_status_t   trace_reg;
  stage_status_t   trace_next;

  assign we    = writes_reg(stage_in);
  assign wdata = XLEN'(stage_in.data.data);

  reg_file #(
    .XLEN        (XLEN),
    .REG_COUNT   (REG_COUNT),
    .WRITE_BYPASS(WRITE_BYPASS)
  ) u_reg_file (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(stage_in.data.address),
    .wdata(wdata),
    .a1   (reg_a1),
    .a2   (reg_a2),
    .rd1  (reg_rd1),
    .rd2  (reg_rd2)
  );

  // Every valid record retires, including stores and branches with no register result.
  always_comb begin
    cycle_count_next   = cycle_count_reg + 64'd1;
    retired_count_next = retired_count_reg + (stage_in.valid ? 64'd1 : 64'd0);
    trace_next         = stage_in.valid ? stage_in : STAGE_IDLE;
    trace_next.ready   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_reg   <= '0;
      retired_count_reg <= '0;
      trace_reg         <= STAGE_IDLE;
    end else begin
      cycle_count_reg   <= cycle_count_next;
      retired_count_reg <= retired_count_next;
      trace_reg         <= trace_next;
    end
  end

  assign stage_out     = trace_reg;
  assign retire_valid  = trace_reg.valid;
  assign retire_pc     = trace_reg.pc;
  assign cycle_count   = cycle_count_reg;
  assign retired_count = retired_count_reg;

endmodule
